// File: rtl/fp32_row_replay_buf.sv
// Ping-pong row buffer: captures a score row, waits for that row's max from
// fp32_row_max, then replays each element paired with the row max.
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high; once out_valid rises, out_* stay stable until out_ready accepts.
module fp32_row_replay_buf #(
  parameter int T = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_fp32,
  input  logic        row_start,
  input  logic        row_last,
  output logic        in_ready,
  input  logic        max_valid,
  input  logic [31:0] max_fp32,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_fp32,
  output logic [31:0] out_max,
  output logic        out_first,
  output logic        out_last,
  output logic        err
);
  localparam int CNT_W = (T <= 1) ? 1 : $clog2(T + 1);
  localparam int IDX_W = (T <= 1) ? 1 : $clog2(T);
  localparam logic [CNT_W-1:0] T_CNT = CNT_W'(T);

  typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_WAIT_MAX, S_READY} bank_st_e;

  bank_st_e         r_st[2];
  bank_st_e         w_st_nxt[2];
  logic [CNT_W-1:0] r_len[2];
  logic [CNT_W-1:0] w_len_nxt[2];
  logic [31:0]      r_elem[2][T];
  logic [31:0]      r_max[2];
  logic             r_wr_bank, w_wr_bank_nxt;
  logic             r_rd_bank, w_rd_bank_nxt;
  // Load pointer: next element to move into the output register. It runs
  // ahead of r_rd_bank, which names the bank whose beat sits in the output.
  logic             r_ld_bank;
  logic [CNT_W-1:0] r_ld_idx;
  logic             r_out_valid, r_out_first, r_out_last, r_err;
  logic [31:0]      r_out_fp32, r_out_max;

  logic             w_in_ready, w_acc, w_wr_en, w_err_set;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_max_tgt, w_max_hit;
  logic             w_fire, w_slot_free, w_ld_ready, w_ld_bypass, w_load, w_ld_last;

  assign w_in_ready  = (r_st[r_wr_bank] == S_EMPTY) || (r_st[r_wr_bank] == S_FILLING);
  assign w_acc       = in_valid && w_in_ready;
  // Oldest WAIT_MAX bank: the draining bank first, otherwise the other one.
  assign w_max_tgt   = (r_st[r_rd_bank] == S_WAIT_MAX) ? r_rd_bank : ~r_rd_bank;
  assign w_max_hit   = max_valid && (r_st[w_max_tgt] == S_WAIT_MAX);
  assign w_fire      = r_out_valid && out_ready;
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_ld_ready  = (r_st[r_ld_bank] == S_READY);
  // Bypass lets the first beat load on the same edge the max arrives.
  assign w_ld_bypass = w_max_hit && (w_max_tgt == r_ld_bank);
  assign w_load      = w_slot_free && (w_ld_ready || w_ld_bypass);
  assign w_ld_last   = (r_ld_idx == r_len[r_ld_bank] - CNT_W'(1));

  // Next-state of both bank FSMs, write/read bank pointers and error detection.
  always_comb begin
    w_st_nxt      = r_st;
    w_len_nxt     = r_len;
    w_wr_bank_nxt = r_wr_bank;
    w_rd_bank_nxt = r_rd_bank;
    w_wr_en       = 1'b0;
    w_wr_idx      = '0;
    w_err_set     = 1'b0;
    if (in_valid && !w_in_ready) begin
      w_err_set = 1'b1;
    end else if (w_acc) begin
      if (row_start) begin
        // A new row_start restarts the bank, discarding any partial row.
        w_wr_en                = 1'b1;
        w_len_nxt[r_wr_bank]   = CNT_W'(1);
        w_st_nxt[r_wr_bank]    = row_last ? S_WAIT_MAX : S_FILLING;
        if (row_last) w_wr_bank_nxt = ~r_wr_bank;
      end else if (r_st[r_wr_bank] == S_EMPTY) begin
        w_err_set = 1'b1;
      end else if (r_len[r_wr_bank] == T_CNT) begin
        // Overflow beat is dropped; a row_last on it still closes the row.
        w_err_set = 1'b1;
        if (row_last) begin
          w_st_nxt[r_wr_bank] = S_WAIT_MAX;
          w_wr_bank_nxt       = ~r_wr_bank;
        end
      end else begin
        w_wr_en              = 1'b1;
        w_wr_idx             = r_len[r_wr_bank][IDX_W-1:0];
        w_len_nxt[r_wr_bank] = r_len[r_wr_bank] + CNT_W'(1);
        if (row_last) begin
          w_st_nxt[r_wr_bank] = S_WAIT_MAX;
          w_wr_bank_nxt       = ~r_wr_bank;
        end
      end
    end
    if (max_valid) begin
      if (w_max_hit) w_st_nxt[w_max_tgt] = S_READY;
      else           w_err_set           = 1'b1;
    end
    if (w_fire && r_out_last) begin
      w_st_nxt[r_rd_bank] = S_EMPTY;
      w_rd_bank_nxt       = ~r_rd_bank;
    end
  end

  // Bank state, lengths and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st[0]   <= S_EMPTY;
      r_st[1]   <= S_EMPTY;
      r_len[0]  <= '0;
      r_len[1]  <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_ld_bank <= 1'b0;
      r_ld_idx  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_st      <= w_st_nxt;
      r_len     <= w_len_nxt;
      r_wr_bank <= w_wr_bank_nxt;
      r_rd_bank <= w_rd_bank_nxt;
      r_err     <= r_err | w_err_set;
      if (w_load) begin
        if (w_ld_last) begin
          r_ld_bank <= ~r_ld_bank;
          r_ld_idx  <= '0;
        end else begin
          r_ld_idx  <= r_ld_idx + CNT_W'(1);
        end
      end
    end
  end

  // Row storage and per-bank max; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_elem[r_wr_bank][w_wr_idx] <= in_fp32;
    if (w_max_hit) r_max[w_max_tgt] <= max_fp32;
  end

  // Output register: loads when empty or being accepted, holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_fp32  <= '0;
      r_out_max   <= '0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_fp32  <= r_elem[r_ld_bank][r_ld_idx[IDX_W-1:0]];
      r_out_max   <= w_ld_ready ? r_max[r_ld_bank] : max_fp32;
      r_out_first <= (r_ld_idx == '0);
      r_out_last  <= w_ld_last;
    end else if (w_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_fp32  = r_out_fp32;
  assign out_max   = r_out_max;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;
  assign err       = r_err;
endmodule

// File: tb/tb_fp32_row_replay_buf.sv
// Directed bench for fp32_row_replay_buf: expected replay beats are queued
// when rows and maxima are driven, and popped as the DUT hands them out.
module tb_fp32_row_replay_buf;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_fp32 = '0;
  logic        row_start = 1'b0;
  logic        row_last = 1'b0;
  logic        in_ready;
  logic        max_valid = 1'b0;
  logic [31:0] max_fp32 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_fp32;
  logic [31:0] out_max;
  logic        out_first;
  logic        out_last;
  logic        err;

  int n_total = 0;
  int n_bad   = 0;
  logic [65:0] exp_q[$];
  logic [65:0] held;
  logic        hold_chk = 1'b0;
  logic [65:0] cur;

  assign cur = {out_fp32, out_max, out_first, out_last};

  fp32_row_replay_buf #(.T(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_fp32(in_fp32),
    .row_start(row_start), .row_last(row_last), .in_ready(in_ready),
    .max_valid(max_valid), .max_fp32(max_fp32), .out_valid(out_valid),
    .out_ready(out_ready), .out_fp32(out_fp32), .out_max(out_max),
    .out_first(out_first), .out_last(out_last), .err(err)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: pop on every handshake, check stalled beats hold.
  always @(negedge clk) begin
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) chk("hold", {out_valid, cur[64:0]}, {1'b1, held[64:0]});
      if (hold_chk) chk("hold_fp32", {34'd0, cur[65]}, {34'd0, held[65]});
      if (out_valid && out_ready) begin
        n_total++;
        assert (exp_q.size() != 0) else begin
          n_bad++;
          $error("FAIL extra_beat got=%h exp=none", cur);
        end
        if (exp_q.size() != 0) chk("beat", cur, exp_q.pop_front());
      end
      hold_chk = out_valid && !out_ready;
      held     = cur;
    end
  end

  // Driver tasks: all start and end at posedge+1.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic s, input logic l);
    in_valid = 1'b1; in_fp32 = d; row_start = s; row_last = l;
    step();
    in_valid = 1'b0; row_start = 1'b0; row_last = 1'b0;
  endtask

  task automatic send_max(input logic [31:0] m);
    max_valid = 1'b1; max_fp32 = m;
    step();
    max_valid = 1'b0;
  endtask

  task automatic push_row(input logic [31:0] r[$], input logic [31:0] m);
    for (int i = 0; i < r.size(); i++)
      exp_q.push_back({r[i], m, (i == 0), (i == r.size() - 1)});
  endtask

  task automatic send_row(input logic [31:0] r[$]);
    for (int i = 0; i < r.size(); i++)
      send_beat(r[i], (i == 0), (i == r.size() - 1));
  endtask

  task automatic wait_drain(input string tag);
    int cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 100) begin
      step();
      cyc++;
    end
    chk(tag, 66'(exp_q.size()), 66'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    exp_q.delete();
    rst = 1'b0;
    step();
  endtask

  initial begin
    logic [31:0] row[$];
    logic [31:0] r1[$];
    logic        rdy_pat[$];
    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_outs", {out_valid, out_first, out_last, err, 30'd0, out_fp32},
        {4'b0, 30'd0, 32'd0});
    chk("rst_max", {34'd0, out_max}, 66'd0);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("rst_in_ready", {65'd0, in_ready}, 66'd1);
    step();

    // Basic row {1,3,2,-1}, max 3
    out_ready = 1'b1;
    row = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'hBF800000};
    send_row(row);
    push_row(row, 32'h40400000);
    max_valid = 1'b1; max_fp32 = 32'h40400000;
    @(negedge clk);
    chk("lat_pre", {65'd0, out_valid}, 66'd0);
    step();
    max_valid = 1'b0;
    @(negedge clk);
    chk("lat_valid", {65'd0, out_valid}, 66'd1);
    step();
    wait_drain("drain_basic");

    // Two rows stalled, then released back to back
    out_ready = 1'b0;
    row = '{32'h3F000000, 32'h3E800000};
    r1  = '{32'h41000000, 32'hC1000000, 32'h40A00000};
    send_row(row);
    send_row(r1);
    push_row(row, 32'h3F000000);
    send_max(32'h3F000000);
    push_row(r1, 32'h41000000);
    send_max(32'h41000000);
    @(negedge clk);
    chk("full_in_ready", {65'd0, in_ready}, 66'd0);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_bubble", {65'd0, out_valid}, 66'd1);
    end
    step();
    @(negedge clk);
    chk("after_pair", {64'd0, out_valid, in_ready}, 66'd1);
    wait_drain("drain_pair");

    // out_ready toggling 1,0,0,1,...
    out_ready = 1'b0;
    row = '{32'h40800000, 32'h41100000, 32'hC0400000, 32'h3DCCCCCD};
    send_row(row);
    push_row(row, 32'h41100000);
    send_max(32'h41100000);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < rdy_pat.size(); i++) begin
      out_ready = rdy_pat[i];
      step();
    end
    out_ready = 1'b1;
    wait_drain("drain_toggle");

    // Single-element row
    row = '{32'hC0000000};
    send_row(row);
    push_row(row, 32'hC0000000);
    send_max(32'hC0000000);
    wait_drain("drain_len1");
    @(negedge clk);
    chk("err_clean", {65'd0, err}, 66'd0);
    step();

    // Stray max pulse
    send_max(32'h12345678);
    @(negedge clk);
    chk("err_stray", {65'd0, err}, 66'd1);
    step();
    do_reset();
    @(negedge clk);
    chk("err_cleared", {65'd0, err}, 66'd0);
    step();

    // Overflow: five beats without row_last
    send_beat(32'h3F800001, 1'b1, 1'b0);
    for (int i = 2; i <= 5; i++) send_beat(32'h3F800000 + 32'(i), 1'b0, 1'b0);
    @(negedge clk);
    chk("err_ovf", {64'd0, err, in_ready}, 66'd3);
    step();
    row = '{32'h41200000};
    send_row(row);
    push_row(row, 32'h41200000);
    send_max(32'h41200000);
    wait_drain("drain_ovf");

    // Reset while bank 0 is mid-drain
    do_reset();
    out_ready = 1'b0;
    row = '{32'h40E00000, 32'h40C00000, 32'h41300000, 32'h3F400000};
    send_row(row);
    push_row(row, 32'h41300000);
    send_max(32'h41300000);
    @(negedge clk);
    chk("pre_rst_valid", {65'd0, out_valid}, 66'd1);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async", {64'd0, out_valid, out_first}, 66'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    row = '{32'h40A00000, 32'h40C00000};
    send_row(row);
    push_row(row, 32'h40C00000);
    send_max(32'h40C00000);
    wait_drain("drain_post_rst");
    @(negedge clk);
    chk("final_err", {65'd0, err}, 66'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
